hack_memory: RTL and testbench

Data-memory subsystem directly downstream of the Hack CPU: it consumes `addressM`, `outM` and `writeM` and returns `inM`. It implements the Hack memory map:
- 16K-word data RAM.
- 8K-word screen buffer, with a second read port for the display controller.
- Keyboard register fed by a buffered key-event handshake, so no keystroke is lost while the program is not polling.

---
 rtl/hack_memory_if.sv | 36 +++
 rtl/hack_memory.sv | 129 ++++++++++++
 tb/tb_hack_memory.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hack_memory_if.sv
// hack_memory_if
// Bundles the three traffic groups seen by the Hack data-memory subsystem:
//   CPU data bus   : addressM, outM, writeM -> inM
//   display port   : scr_addr, scr_rd_en -> scr_rd_data, scr_rd_valid
//   key handshake  : kbd_valid, kbd_code -> kbd_ready
// The memory subsystem connects through the slave modport; the CPU,
// display controller and key source (or a bench) use the master modport.
interface hack_memory_if;
    logic [14:0] addressM;
    logic [15:0] outM;
    logic        writeM;
    logic [15:0] inM;

    logic [12:0] scr_addr;
    logic        scr_rd_en;
    logic [15:0] scr_rd_data;
    logic        scr_rd_valid;

    logic        kbd_valid;
    logic [15:0] kbd_code;
    logic        kbd_ready;

    modport slave (
        input  addressM, outM, writeM,
        input  scr_addr, scr_rd_en,
        input  kbd_valid, kbd_code,
        output inM, scr_rd_data, scr_rd_valid, kbd_ready
    );

    modport master (
        output addressM, outM, writeM,
        output scr_addr, scr_rd_en,
        output kbd_valid, kbd_code,
        input  inM, scr_rd_data, scr_rd_valid, kbd_ready
    );
endinterface

// File: rtl/hack_memory.sv
// hack_memory
// Hack data-memory map behind the CPU:
//   0x0000-0x3FFF  16K-word RAM
//   0x4000-0x5FFF  8K-word screen buffer (also readable by the display port)
//   0x6000         keyboard register, fed from a small key-event FIFO
//   0x6001-0x7FFF  unmapped (reads 0, writes dropped)
// Ports:
//   clk    single rising-edge clock
//   reset  asynchronous, active-low
//   bus    hack_memory_if.slave (CPU bus, display read port, key handshake)
// Parameter:
//   KBD_DEPTH  key-event FIFO depth, power of two, >= 2
module hack_memory #(
    parameter int KBD_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    hack_memory_if.slave  bus
);

    localparam int PW = $clog2(KBD_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(KBD_DEPTH);

    logic [15:0] ram     [0:16383];
    logic [15:0] screen  [0:8191];
    logic [15:0] kbd_mem [0:KBD_DEPTH-1];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [15:0]   kbd_reg;
    logic          kbd_seen;

    logic [15:0]   scr_data_q;
    logic          scr_valid_q;

    logic sel_ram;
    logic sel_screen;
    logic sel_kbd;
    logic kbd_poll;
    logic push;
    logic pop;

    // Address decode; bit 14 clear is RAM, 10x is screen, exactly 0x6000 is KBD.
    assign sel_ram    = (bus.addressM[14] == 1'b0);
    assign sel_screen = (bus.addressM[14:13] == 2'b10);
    assign sel_kbd    = (bus.addressM == 15'h6000);
    assign kbd_poll   = sel_kbd && !bus.writeM;

    // The FIFO is popped only once the program has read the current key,
    // and the pop looks at the pre-edge count, so a fresh event never
    // bypasses straight into kbd_reg on the edge it arrives.
    assign bus.kbd_ready = (count < DEPTH_C);
    assign push          = bus.kbd_valid && bus.kbd_ready;
    assign pop           = (count != '0) && kbd_seen;

    assign bus.inM = sel_ram    ? ram[bus.addressM[13:0]]    :
                     sel_screen ? screen[bus.addressM[12:0]] :
                     sel_kbd    ? kbd_reg                    :
                                  16'h0000;

    assign bus.scr_rd_data  = scr_data_q;
    assign bus.scr_rd_valid = scr_valid_q;

    // RAM write port; contents survive reset, but no write lands while held in reset.
    always_ff @(posedge clk) begin
        if (reset && bus.writeM && sel_ram) begin
            ram[bus.addressM[13:0]] <= bus.outM;
        end
    end

    // Screen write port from the CPU side.
    always_ff @(posedge clk) begin
        if (reset && bus.writeM && sel_screen) begin
            screen[bus.addressM[12:0]] <= bus.outM;
        end
    end

    // Display read port; sampling the array with a non-blocking read gives
    // the old word when the CPU writes the same location on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scr_data_q  <= 16'h0000;
            scr_valid_q <= 1'b0;
        end else begin
            scr_valid_q <= bus.scr_rd_en;
            if (bus.scr_rd_en) begin
                scr_data_q <= screen[bus.scr_addr];
            end
        end
    end

    // Key FIFO storage; pointer state lives in the control block below.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            kbd_mem[wr_ptr] <= bus.kbd_code;
        end
    end

    // Key FIFO control and keyboard register. A pop takes priority over a
    // poll on the same edge so kbd_seen always ends low after a pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            kbd_reg  <= 16'h0000;
            kbd_seen <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + PW'(1);
                kbd_reg  <= kbd_mem[rd_ptr];
                kbd_seen <= 1'b0;
            end else if (kbd_poll) begin
                kbd_seen <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_hack_memory.sv
// tb_hack_memory
// Drives hack_memory through its interface with directed and $urandom
// stimulus and compares against a queue/array model of the memory map.
module tb_hack_memory;

    localparam int KBD_DEPTH = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    hack_memory_if bus ();

    hack_memory #(.KBD_DEPTH(KBD_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] ram_m [int];
    logic [15:0] scr_m [int];
    logic [15:0] kq_m [$];
    logic [15:0] src_q [$];
    logic [15:0] kbd_m;
    bit          seen_m;
    logic [15:0] scr_data_m;
    bit          scr_valid_m;

    task automatic model_reset();
        kq_m.delete();
        src_q.delete();
        kbd_m       = 16'h0000;
        seen_m      = 1'b1;
        scr_data_m  = 16'h0000;
        scr_valid_m = 1'b0;
    endtask

    function automatic logic [15:0] exp_inm(int a);
        if (a < 'h4000)      return ram_m.exists(a) ? ram_m[a] : 16'hxxxx;
        else if (a < 'h6000) return scr_m.exists(a - 'h4000) ? scr_m[a - 'h4000] : 16'hxxxx;
        else if (a == 'h6000) return kbd_m;
        else                 return 16'h0000;
    endfunction

    // One clock: offer the head of src_q, advance the model from the inputs
    // as they stand at the edge, then wait past the edge.
    task automatic step();
        int a;
        bit accept;
        bit do_pop;
        bus.kbd_valid = (src_q.size() > 0);
        bus.kbd_code  = (src_q.size() > 0) ? src_q[0] : 16'h0000;
        a      = int'(bus.addressM);
        accept = bus.kbd_valid && (kq_m.size() < KBD_DEPTH);
        do_pop = (kq_m.size() > 0) && seen_m;
        if (bus.scr_rd_en) begin
            scr_valid_m = 1'b1;
            scr_data_m  = scr_m.exists(int'(bus.scr_addr)) ? scr_m[int'(bus.scr_addr)] : 16'hxxxx;
        end else begin
            scr_valid_m = 1'b0;
        end
        if (bus.writeM) begin
            if (a < 'h4000)      ram_m[a] = bus.outM;
            else if (a < 'h6000) scr_m[a - 'h4000] = bus.outM;
        end
        if (do_pop) begin
            kbd_m  = kq_m.pop_front();
            seen_m = 1'b0;
        end else if (a == 'h6000 && !bus.writeM) begin
            seen_m = 1'b1;
        end
        if (accept) begin
            kq_m.push_back(bus.kbd_code);
            void'(src_q.pop_front());
        end
        @(posedge clk);
        #1;
        bus.kbd_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.addressM  = 15'h6000;
        bus.outM      = 16'h0000;
        bus.writeM    = 1'b0;
        bus.scr_addr  = 13'h0;
        bus.scr_rd_en = 1'b0;
        bus.kbd_valid = 1'b0;
        bus.kbd_code  = 16'h0000;
        #2 reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.inM !== 16'h0000) begin errors++; $display("[TB] FAIL reset_kbd: got %h expected 0000", bus.inM); end
        checks++; if (bus.kbd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", bus.kbd_ready); end
        checks++; if (bus.scr_rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.scr_rd_valid); end
        checks++; if (bus.scr_rd_data !== 16'h0000) begin errors++; $display("[TB] FAIL reset_scrdata: got %h expected 0000", bus.scr_rd_data); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_ram_screen();
        int addrs[$];
        bus.addressM = 15'h0005; bus.outM = 16'h1234; bus.writeM = 1'b1;
        step();
        bus.writeM = 1'b0; #1;
        checks++; if (bus.inM !== 16'h1234) begin errors++; $display("[TB] FAIL ram_write: got %h expected 1234", bus.inM); end
        bus.addressM = 15'h4000; bus.outM = 16'hBEEF; bus.writeM = 1'b1;
        step();
        bus.writeM = 1'b0; #1;
        checks++; if (bus.inM !== 16'hBEEF) begin errors++; $display("[TB] FAIL scr_write: got %h expected beef", bus.inM); end
        bus.scr_addr = 13'h0; bus.scr_rd_en = 1'b1;
        step();
        bus.scr_rd_en = 1'b0;
        checks++; if (bus.scr_rd_data !== 16'hBEEF || bus.scr_rd_valid !== 1'b1) begin errors++; $display("[TB] FAIL disp_read: got %h/%b expected beef/1", bus.scr_rd_data, bus.scr_rd_valid); end
        step();
        checks++; if (bus.scr_rd_data !== 16'hBEEF || bus.scr_rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL disp_hold: got %h/%b expected beef/0", bus.scr_rd_data, bus.scr_rd_valid); end

        // Random double writes: the second write must not be visible before its edge.
        for (int i = 0; i < 12; i++) begin
            int a;
            logic [15:0] d1, d2;
            a  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(16'h0100, 16'h3FFF)) : int'($urandom_range(16'h4100, 16'h5FFF));
            d1 = 16'($urandom);
            d2 = 16'($urandom);
            addrs.push_back(a);
            bus.addressM = 15'(a); bus.outM = d1; bus.writeM = 1'b1;
            step();
            bus.outM = d2; #1;
            checks++; if (bus.inM !== exp_inm(a)) begin errors++; $display("[TB] FAIL rbw_inm @%h: got %h expected %h", a, bus.inM, exp_inm(a)); end
            step();
            bus.writeM = 1'b0; #1;
            checks++; if (bus.inM !== exp_inm(a)) begin errors++; $display("[TB] FAIL rand_write @%h: got %h expected %h", a, bus.inM, exp_inm(a)); end
        end
        // Read everything back, screen words through both ports.
        foreach (addrs[i]) begin
            bus.addressM = 15'(addrs[i]);
            bus.scr_rd_en = (addrs[i] >= 'h4000);
            bus.scr_addr  = 13'(addrs[i]);
            #1;
            checks++; if (bus.inM !== exp_inm(addrs[i])) begin errors++; $display("[TB] FAIL readback @%h: got %h expected %h", addrs[i], bus.inM, exp_inm(addrs[i])); end
            step();
            if (addrs[i] >= 'h4000) begin
                checks++; if (bus.scr_rd_data !== scr_data_m) begin errors++; $display("[TB] FAIL disp_readback @%h: got %h expected %h", addrs[i], bus.scr_rd_data, scr_data_m); end
            end
        end
        bus.scr_rd_en = 1'b0;
    endtask

    task automatic test_unmapped();
        bus.addressM = 15'h6000; bus.outM = 16'hFFFF; bus.writeM = 1'b1;
        step();
        bus.addressM = 15'h7FFF;
        step();
        bus.writeM = 1'b0; #1;
        checks++; if (bus.inM !== 16'h0000) begin errors++; $display("[TB] FAIL unmapped_7fff: got %h expected 0000", bus.inM); end
        bus.addressM = 15'h6000; #1;
        checks++; if (bus.inM !== 16'h0000) begin errors++; $display("[TB] FAIL kbd_write_dropped: got %h expected 0000", bus.inM); end
        bus.addressM = 15'h0005; #1;
        checks++; if (bus.inM !== 16'h1234) begin errors++; $display("[TB] FAIL ram_unchanged: got %h expected 1234", bus.inM); end
        for (int i = 0; i < 4; i++) begin
            bus.addressM = 15'($urandom_range(16'h6001, 16'h7FFF)); #1;
            checks++; if (bus.inM !== 16'h0000) begin errors++; $display("[TB] FAIL unmapped_rand @%h: got %h expected 0000", bus.addressM, bus.inM); end
        end
    endtask

    task automatic test_key_order();
        logic [15:0] obs[$];
        int hold[$];
        logic [15:0] last;
        last = kbd_m;
        src_q = '{16'd65, 16'd66, 16'd0};
        bus.addressM = 15'h6000; bus.writeM = 1'b0;
        for (int c = 0; c < 24; c++) begin
            step();
            checks++; if (bus.inM !== kbd_m) begin errors++; $display("[TB] FAIL order_kbd cyc%0d: got %h expected %h", c, bus.inM, kbd_m); end
            checks++; if (bus.kbd_ready !== (kq_m.size() < KBD_DEPTH)) begin errors++; $display("[TB] FAIL order_ready cyc%0d: got %b expected %b", c, bus.kbd_ready, kq_m.size() < KBD_DEPTH); end
            if (bus.inM !== last) begin
                obs.push_back(bus.inM); hold.push_back(1); last = bus.inM;
            end else if (obs.size() > 0) begin
                hold[hold.size() - 1]++;
            end
        end
        checks++;
        if (obs.size() != 3) begin
            errors++; $display("[TB] FAIL order_count: got %0d changes expected 3", obs.size());
        end else if (obs[0] !== 16'd65 || obs[1] !== 16'd66 || obs[2] !== 16'd0) begin
            errors++; $display("[TB] FAIL order_seq: got %0d,%0d,%0d expected 65,66,0", obs[0], obs[1], obs[2]);
        end else if (hold[0] < 2 || hold[1] < 2) begin
            errors++; $display("[TB] FAIL order_hold: got %0d,%0d cycles expected >=2", hold[0], hold[1]);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] codes[$];
        logic [15:0] obs[$];
        logic [15:0] last;
        logic [15:0] base;
        int n;
        base = 16'($urandom_range(16'h0100, 16'h7000));
        for (int i = 0; i < KBD_DEPTH + 2; i++) codes.push_back(base + 16'(i));
        src_q = codes;
        bus.addressM = 15'h0000; bus.writeM = 1'b0;
        n = 0;
        while (src_q.size() > 1 && n < 20) begin
            step();
            n++;
        end
        checks++; if (n >= 20) begin errors++; $display("[TB] FAIL bp_fill_timeout: got %0d pending expected 1", src_q.size()); end
        for (int c = 0; c < 3; c++) begin
            checks++; if (bus.kbd_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_low cyc%0d: got %b expected 0", c, bus.kbd_ready); end
            step();
        end
        bus.addressM = 15'h6000; #1;
        checks++; if (bus.inM !== codes[0]) begin errors++; $display("[TB] FAIL bp_first: got %h expected %h", bus.inM, codes[0]); end
        last = codes[0];
        for (int c = 0; c < 30; c++) begin
            step();
            checks++; if (bus.inM !== kbd_m) begin errors++; $display("[TB] FAIL bp_kbd cyc%0d: got %h expected %h", c, bus.inM, kbd_m); end
            checks++; if (bus.kbd_ready !== (kq_m.size() < KBD_DEPTH)) begin errors++; $display("[TB] FAIL bp_ready cyc%0d: got %b expected %b", c, bus.kbd_ready, kq_m.size() < KBD_DEPTH); end
            if (bus.inM !== last) begin obs.push_back(bus.inM); last = bus.inM; end
        end
        checks++;
        if (obs.size() != KBD_DEPTH + 1) begin
            errors++; $display("[TB] FAIL bp_count: got %0d events expected %0d", obs.size(), KBD_DEPTH + 1);
        end else begin
            foreach (obs[i]) begin
                if (obs[i] !== codes[i + 1]) begin
                    errors++; $display("[TB] FAIL bp_seq[%0d]: got %h expected %h", i, obs[i], codes[i + 1]);
                    break;
                end
            end
        end
    endtask

    task automatic test_collision();
        bus.addressM = 15'h4007; bus.outM = 16'hAAAA; bus.writeM = 1'b1;
        step();
        bus.outM = 16'h00FF; bus.scr_addr = 13'd7; bus.scr_rd_en = 1'b1;
        step();
        bus.writeM = 1'b0;
        checks++; if (bus.scr_rd_data !== 16'hAAAA || bus.scr_rd_valid !== 1'b1) begin errors++; $display("[TB] FAIL collide_old: got %h/%b expected aaaa/1", bus.scr_rd_data, bus.scr_rd_valid); end
        step();
        checks++; if (bus.scr_rd_data !== 16'h00FF) begin errors++; $display("[TB] FAIL collide_new: got %h expected 00ff", bus.scr_rd_data); end
        bus.scr_rd_en = 1'b0;
    endtask

    task automatic test_async_reset();
        int n;
        src_q = '{16'd66};
        bus.addressM = 15'h6000; bus.writeM = 1'b0;
        n = 0;
        while (kbd_m !== 16'd66 && n < 10) begin step(); n++; end
        bus.addressM = 15'h0000;
        for (int i = 0; i < 3; i++) src_q.push_back(16'($urandom_range(16'h0100, 16'hFFFF)));
        n = 0;
        while (src_q.size() > 0 && n < 10) begin step(); n++; end
        bus.scr_addr = 13'd7; bus.scr_rd_en = 1'b1;
        step();
        bus.scr_rd_en = 1'b0;
        bus.addressM = 15'h6000; #1;
        checks++; if (bus.inM !== 16'd66 || bus.scr_rd_valid !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset: got %h/%b expected 0042/1", bus.inM, bus.scr_rd_valid); end
        #2 reset = 1'b0;
        model_reset();
        #1;
        checks++; if (bus.inM !== 16'h0000) begin errors++; $display("[TB] FAIL areset_kbd: got %h expected 0000", bus.inM); end
        checks++; if (bus.kbd_ready !== 1'b1) begin errors++; $display("[TB] FAIL areset_ready: got %b expected 1", bus.kbd_ready); end
        checks++; if (bus.scr_rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL areset_valid: got %b expected 0", bus.scr_rd_valid); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        bus.addressM = 15'h0005; #1;
        checks++; if (bus.inM !== 16'h1234) begin errors++; $display("[TB] FAIL ram_kept: got %h expected 1234", bus.inM); end
        bus.addressM = 15'h6000;
        for (int c = 0; c < 6; c++) begin
            step();
            checks++; if (bus.inM !== 16'h0000) begin errors++; $display("[TB] FAIL flushed cyc%0d: got %h expected 0000", c, bus.inM); end
        end
    endtask

    initial begin
        test_reset();
        test_ram_screen();
        test_unmapped();
        test_key_order();
        test_backpressure();
        test_collision();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
